// File: rtl/multicycle_mips_core.sv
// multicycle_mips_core
//   Multi-cycle MIPS subset core (add/sub/and/or/slt/sll/srl, addi, lw, sw,
//   beq, j). One instruction is sequenced through FETCH/DECODE/EXEC/MEM/WB
//   by an FSM. A single unified memory is reached through a req/ready
//   handshake that tolerates wait states. Faults stop the core in HALT
//   until reset.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   mem_req/mem_we        access request, 1 = write
//   mem_addr/mem_wdata    word-aligned byte address, store data
//   mem_rdata/mem_ready   read data, transfer-complete strobe
//   pc_out                architectural PC
//   halted/halt_cause     sticky stop flag; 1 illegal, 2 misaligned, 3 timeout
//   dbg_raddr/dbg_rdata   combinational register-file peek ($0 reads 0)
//   cycle_cnt/instret     only when MCPU_PERF_CNT_EN is defined
//
// Optional feature macro: MCPU_PERF_CNT_EN (cycle and retired-instruction counters).
module multicycle_mips_core #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned MAX_WAIT   = 0,
   parameter int unsigned WAIT_CNT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc_out,
   output logic        halted,
   output logic [1:0]  halt_cause,
   input  logic [4:0]  dbg_raddr,
   output logic [31:0] dbg_rdata
`ifdef MCPU_PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret
`endif
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23;
   localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
   localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A, F_SLL = 6'h00, F_SRL = 6'h02;

   localparam bit TIMEOUT_EN = (MAX_WAIT != 0);
   // Value the counter holds in the last permitted stall cycle.
   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

   state_t r_state, w_state_next;
   logic [31:0] r_pc, r_ir, r_a, r_b, r_alu_out, r_mdr;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic [1:0]  r_halt_cause, w_fault_cause;
   logic [31:0] r_regs [0:31];

   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
   logic [31:0] w_imm_sext, w_alu_res, w_wb_data;
   logic [4:0]  w_wb_addr;
   logic        w_legal, w_in_access, w_xfer, w_stall, w_timeout, w_wb_en;

   assign w_op       = r_ir[31:26];
   assign w_rs       = r_ir[25:21];
   assign w_rt       = r_ir[20:16];
   assign w_rd       = r_ir[15:11];
   assign w_shamt    = r_ir[10:6];
   assign w_funct    = r_ir[5:0];
   assign w_imm_sext = {{16{r_ir[15]}}, r_ir[15:0]};

   // Kept free of mem_req so the handshake terms do not loop through rst gating.
   assign w_in_access = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_xfer      = w_in_access && mem_ready;
   assign w_stall     = w_in_access && !mem_ready;
   assign w_timeout   = TIMEOUT_EN && w_stall && (r_wait_cnt == WAIT_LAST);

   assign mem_req    = w_in_access && !rst;
   assign mem_wdata  = r_b;
   assign pc_out     = r_pc;
   assign halted     = (r_state == S_HALT);
   assign halt_cause = r_halt_cause;
   assign dbg_rdata  = (dbg_raddr == 5'd0) ? 32'd0 : r_regs[dbg_raddr];

   always_comb begin
      w_legal = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            case (w_funct)
               F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL: w_legal = 1'b1;
               default: w_legal = 1'b0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: w_legal = 1'b1;
         default: w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_alu_res = 32'd0;
      if (w_op == OP_RTYPE) begin
         case (w_funct)
            F_ADD:   w_alu_res = r_a + r_b;
            F_SUB:   w_alu_res = r_a - r_b;
            F_AND:   w_alu_res = r_a & r_b;
            F_OR:    w_alu_res = r_a | r_b;
            F_SLT:   w_alu_res = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
            F_SLL:   w_alu_res = r_b << w_shamt;
            F_SRL:   w_alu_res = r_b >> w_shamt;
            default: w_alu_res = 32'd0;
         endcase
      end else if (w_op == OP_ADDI || w_op == OP_LW || w_op == OP_SW) begin
         w_alu_res = r_a + w_imm_sext;
      end
   end

   // Next-state and memory-port outputs.
   always_comb begin
      w_state_next  = r_state;
      w_fault_cause = 2'd0;
      mem_we        = 1'b0;
      mem_addr      = r_pc;
      case (r_state)
         S_FETCH: begin
            if (w_xfer) begin
               w_state_next = S_DECODE;
            end else if (w_timeout) begin
               w_state_next  = S_HALT;
               w_fault_cause = 2'd3;
            end
         end
         S_DECODE: begin
            if (!w_legal) begin
               w_state_next  = S_HALT;
               w_fault_cause = 2'd1;
            end else if (w_op == OP_J) begin
               w_state_next = S_FETCH;
            end else begin
               w_state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (w_op == OP_BEQ) begin
               w_state_next = S_FETCH;
            end else if (w_op == OP_LW || w_op == OP_SW) begin
               // Misaligned effective address stops here, before any request.
               if (w_alu_res[1:0] != 2'b00) begin
                  w_state_next  = S_HALT;
                  w_fault_cause = 2'd2;
               end else begin
                  w_state_next = S_MEM;
               end
            end else begin
               w_state_next = S_WB;
            end
         end
         S_MEM: begin
            mem_we   = (w_op == OP_SW);
            mem_addr = r_alu_out;
            if (w_xfer) begin
               w_state_next = (w_op == OP_SW) ? S_FETCH : S_WB;
            end else if (w_timeout) begin
               w_state_next  = S_HALT;
               w_fault_cause = 2'd3;
            end
         end
         S_WB:    w_state_next = S_FETCH;
         default: w_state_next = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_ir         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_alu_out    <= '0;
         r_mdr        <= '0;
         r_wait_cnt   <= '0;
         r_halt_cause <= 2'd0;
      end else begin
         r_wait_cnt <= w_stall ? r_wait_cnt + 1'b1 : '0;
         case (r_state)
            S_FETCH: begin
               if (w_xfer) begin
                  r_ir <= mem_rdata;
                  r_pc <= r_pc + 32'd4;
               end
            end
            S_DECODE: begin
               r_a       <= (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
               r_b       <= (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];
               // Branch target parked in ALUOut; r_pc already points past this instruction.
               r_alu_out <= r_pc + {w_imm_sext[29:0], 2'b00};
               if (w_legal && w_op == OP_J) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
            end
            S_EXEC: begin
               r_alu_out <= w_alu_res;
               if (w_op == OP_BEQ && r_a == r_b) r_pc <= r_alu_out;
            end
            S_MEM: begin
               if (w_xfer) r_mdr <= mem_rdata;
            end
            default: ;
         endcase
         if (r_state != S_HALT && w_state_next == S_HALT) r_halt_cause <= w_fault_cause;
      end
   end

   assign w_wb_en   = (r_state == S_WB);
   assign w_wb_addr = (w_op == OP_RTYPE) ? w_rd : w_rt;
   assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_alu_out;

   // Register 0 is held at zero, so writes aimed at it vanish.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_reg
         always_ff @(posedge clk) begin
            if (rst || gi == 0)                                  r_regs[gi] <= '0;
            else if (w_wb_en && w_wb_addr == 5'(gi))             r_regs[gi] <= w_wb_data;
         end
      end
   endgenerate

`ifdef MCPU_PERF_CNT_EN
   logic [31:0] r_cycle_cnt, r_instret;
   logic        w_retire;

   assign w_retire = (r_state == S_DECODE && w_legal && w_op == OP_J)
                   || (r_state == S_EXEC && w_op == OP_BEQ)
                   || (r_state == S_MEM && w_xfer && w_op == OP_SW)
                   || (r_state == S_WB);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycle_cnt <= '0;
         r_instret   <= '0;
      end else begin
         if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (w_retire)          r_instret   <= r_instret + 32'd1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
   assign instret   = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Bench for multicycle_mips_core: directed programs plus random straight-line
// programs checked against an instruction-level reference interpreter that
// also accounts the expected cycle count from per-class latencies.
module tb_multicycle_mips_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req, mem_we, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] pc_out, dbg_rdata;
   logic        halted;
   logic [1:0]  halt_cause;
   logic [4:0]  dbg_raddr = 5'd0;
`ifdef MCPU_PERF_CNT_EN
   logic [31:0] cycle_cnt, instret;
`endif

   multicycle_mips_core #(.RESET_PC(32'h100), .MAX_WAIT(4), .WAIT_CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .pc_out(pc_out), .halted(halted), .halt_cause(halt_cause),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
`ifdef MCPU_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- memory model (owns all its state) ----------------
   logic [31:0] img [0:1023];
   logic [31:0] mem [0:1023];
   int          wait_states = 0;
   bit          ready_low = 1'b0;
   int          req_cycles, we_cycles, xfers, stab_err, wcnt;
   bit          active;
   logic [31:0] h_addr, h_wdata;
   logic        h_we;
   logic [31:0] rd_log [$];

   always @(negedge clk) begin
      if (rst) begin
         mem_ready = 1'b0; mem_rdata = 32'd0; active = 1'b0;
         req_cycles = 0; we_cycles = 0; xfers = 0; stab_err = 0; wcnt = 0;
         rd_log.delete();
         for (int i = 0; i < 1024; i++) mem[i] = img[i];
      end else if (mem_req) begin
         req_cycles++;
         if (mem_we) we_cycles++;
         if (mem_addr[1:0] != 2'b00) stab_err++;
         if (active) begin
            if (mem_addr !== h_addr || mem_we !== h_we || (mem_we && mem_wdata !== h_wdata)) stab_err++;
            wcnt++;
         end else begin
            active = 1'b1; wcnt = 0;
            h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
         end
         mem_ready = !ready_low && (wcnt >= wait_states);
         if (mem_ready) begin
            active = 1'b0;
            xfers++;
            if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            else begin
               mem_rdata = mem[mem_addr[11:2]];
               rd_log.push_back(mem_addr);
            end
         end
      end else begin
         mem_ready = 1'b0;
         active    = 1'b0;
      end
   end

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
   endfunction
   function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction
   function automatic logic [31:0] enc_j(int word_idx);
      return {6'h02, 26'(word_idx)};
   endfunction

   localparam logic [31:0] ILLEGAL = 32'hFC00_0000;
   localparam int PROG_W = 64;   // word index of 0x100
   localparam int DATA_W = 512;  // word index of 0x800

   task automatic clear_img();
      for (int i = 0; i < 1024; i++) img[i] = ILLEGAL;
      for (int i = DATA_W; i < DATA_W + 16; i++) img[i] = 32'd0;
   endtask

   // ---------------- reference interpreter ----------------
   logic [31:0] ref_mem [0:1023];
   logic [31:0] ref_regs [0:31];
   logic [31:0] ref_pc;
   int          ref_cause, ref_cyc;

   task automatic ref_run(input int w);
      logic [31:0] ir, a, b, imm, ea, res;
      for (int i = 0; i < 1024; i++) ref_mem[i] = img[i];
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
      ref_pc = 32'h100; ref_cause = 0; ref_cyc = 0;
      for (int step = 0; step < 500 && ref_cause == 0; step++) begin
         ir = ref_mem[ref_pc[11:2]];
         ref_pc = ref_pc + 4;
         ref_cyc += 2 + w;               // fetch with waits, then decode
         a   = ref_regs[ir[25:21]];
         b   = ref_regs[ir[20:16]];
         imm = {{16{ir[15]}}, ir[15:0]};
         ea  = a + imm;
         case (ir[31:26])
            6'h00: begin
               ref_cyc += 2;
               case (ir[5:0])
                  6'h20: res = a + b;
                  6'h22: res = a - b;
                  6'h24: res = a & b;
                  6'h25: res = a | b;
                  6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                  6'h00: res = b << ir[10:6];
                  6'h02: res = b >> ir[10:6];
                  default: begin ref_cause = 1; ref_cyc -= 2; res = 32'd0; end
               endcase
               if (ref_cause == 0) ref_regs[ir[15:11]] = res;
            end
            6'h08: begin ref_cyc += 2; ref_regs[ir[20:16]] = ea; end
            6'h23: begin
               ref_cyc += 1;
               if (ea[1:0] != 2'b00) ref_cause = 2;
               else begin ref_cyc += 2 + w; ref_regs[ir[20:16]] = ref_mem[ea[11:2]]; end
            end
            6'h2B: begin
               ref_cyc += 1;
               if (ea[1:0] != 2'b00) ref_cause = 2;
               else begin ref_cyc += 1 + w; ref_mem[ea[11:2]] = b; end
            end
            6'h04: begin ref_cyc += 1; if (a == b) ref_pc = ref_pc + (imm << 2); end
            6'h02: ref_pc = {ref_pc[31:28], ir[25:0], 2'b00};
            default: ref_cause = 1;
         endcase
         ref_regs[0] = 32'd0;
      end
   endtask

   // ---------------- random program generator ----------------
   task automatic gen_random_prog(input int n);
      logic [5:0] fn_tab [7];
      logic [5:0] fn;
      int k, rs, rt, rd, sh;
      fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
      clear_img();
      for (int i = DATA_W; i < DATA_W + 16; i++) img[i] = $urandom;
      for (int i = 0; i < n; i++) begin
         k  = $urandom_range(0, 99);
         rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
         if (k < 35) begin
            fn = fn_tab[$urandom_range(0, 6)];
            sh = (fn == 6'h00 || fn == 6'h02) ? $urandom_range(0, 31) : 0;
            img[PROG_W + i] = enc_r(rs, rt, rd, sh, fn);
         end else if (k < 60) img[PROG_W + i] = enc_i(6'h08, rs, rt, 16'($urandom));
         else if (k < 72)     img[PROG_W + i] = enc_i(6'h2B, 0, rt, 16'(32'h800 + 4 * $urandom_range(0, 15)));
         else if (k < 84)     img[PROG_W + i] = enc_i(6'h23, 0, rt, 16'(32'h800 + 4 * $urandom_range(0, 15)));
         else if (k < 92)     img[PROG_W + i] = enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3)));
         else if (k < 97)     img[PROG_W + i] = enc_j(PROG_W + i + 1 + $urandom_range(0, 3));
         else if (k < 99)     img[PROG_W + i] = enc_i(6'h23, 0, rt, 16'h0801);
         else                 img[PROG_W + i] = enc_r(rs, rt, rd, 0, 6'h3F);
      end
   endtask

   // ---------------- run helpers ----------------
   task automatic do_reset();
      rst = 1'b1;
      dbg_raddr = 5'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic run_until_halt(output int cyc);
      cyc = 0;
      while (!halted && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_val("halt_reached", {31'b0, halted}, 32'd1);
   endtask

   task automatic check_reg(input int idx, input logic [31:0] exp);
      dbg_raddr = 5'(idx);
      #1;
      check_val($sformatf("reg%0d", idx), dbg_rdata, exp);
   endtask

   task automatic load_alu_prog();
      clear_img();
      img[PROG_W + 0] = enc_i(6'h08, 0, 1, 16'd5);
      img[PROG_W + 1] = enc_i(6'h08, 0, 2, 16'hFFFD);
      img[PROG_W + 2] = enc_r(1, 2, 3, 0, 6'h20);
      img[PROG_W + 3] = enc_r(2, 1, 4, 0, 6'h2A);
      img[PROG_W + 4] = enc_i(6'h08, 0, 0, 16'd7);
   endtask

   int cyc;

   initial begin
      // Reset state and first fetch
      load_alu_prog();
      wait_states = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check_val("rst_pc", pc_out, 32'h100);
      check_val("rst_halted", {31'b0, halted}, 32'd0);
      check_val("rst_cause", {30'b0, halt_cause}, 32'd0);
      rst = 1'b0;
      #1;
      check_val("first_req", {31'b0, mem_req}, 32'd1);
      check_val("first_addr", mem_addr, 32'h100);
      @(posedge clk); #1;
      check_val("pc_after_fetch", pc_out, 32'h104);
      $display("reset/first fetch done");

      // ALU program: 4 instructions in 16 cycles + addi $0 (4) + illegal halt (2)
      do_reset();
      run_until_halt(cyc);
      check_val("alu_cycles", 32'(cyc), 32'd22);
      check_val("alu_cause", {30'b0, halt_cause}, 32'd1);
      check_reg(3, 32'd2);
      check_reg(4, 32'd1);
      check_reg(2, 32'hFFFF_FFFD);
      check_reg(0, 32'd0);
      $display("alu program: cycles=%0d pc=%h", cyc, pc_out);

      // sw/lw with 3 wait states
      clear_img();
      img[PROG_W + 0] = enc_i(6'h08, 0, 1, 16'd5);
      img[PROG_W + 1] = enc_i(6'h2B, 0, 1, 16'd8);
      img[PROG_W + 2] = enc_i(6'h23, 0, 5, 16'd8);
      wait_states = 3;
      do_reset();
      run_until_halt(cyc);
      check_val("ldst_cycles", 32'(cyc), 32'd33);
      check_val("ldst_we_cycles", 32'(we_cycles), 32'd4);
      check_val("ldst_stability", 32'(stab_err), 32'd0);
      check_val("ldst_mem", mem[2], 32'd5);
      check_reg(5, 32'd5);
      $display("sw/lw waits: cycles=%0d we_cycles=%0d", cyc, we_cycles);

      // j to 0x20, then beq-to-self loop
      clear_img();
      img[PROG_W] = enc_j(8);
      img[8]      = enc_i(6'h04, 1, 1, 16'hFFFF);
      wait_states = 0;
      do_reset();
      repeat (20) @(posedge clk);
      #1;
      check_val("loop_fetches", 32'(rd_log.size()), 32'd7);
      if (rd_log.size() > 0) check_val("loop_fetch0", rd_log[0], 32'h100);
      for (int i = 1; i < rd_log.size(); i++) check_val($sformatf("loop_fetch%0d", i), rd_log[i], 32'h20);
      check_val("loop_halted", {31'b0, halted}, 32'd0);
      $display("branch loop: fetches=%0d pc=%h", rd_log.size(), pc_out);

      // Misaligned lw
      clear_img();
      img[PROG_W] = enc_i(6'h23, 0, 6, 16'd2);
      do_reset();
      run_until_halt(cyc);
      check_val("misal_cause", {30'b0, halt_cause}, 32'd2);
      check_val("misal_cycles", 32'(cyc), 32'd3);
      check_val("misal_xfers", 32'(xfers), 32'd1);
      check_val("misal_pc", pc_out, 32'h104);
      $display("misaligned lw: cause=%0d cycles=%0d", halt_cause, cyc);

      // Illegal opcode 0x3F
      clear_img();
      do_reset();
      run_until_halt(cyc);
      check_val("illegal_cause", {30'b0, halt_cause}, 32'd1);
      check_val("illegal_cycles", 32'(cyc), 32'd2);
      check_val("illegal_pc", pc_out, 32'h104);
      $display("illegal opcode: cause=%0d cycles=%0d", halt_cause, cyc);

      // Reset in the middle of a stalled fetch
      load_alu_prog();
      do_reset();
      repeat (5) @(posedge clk);
      #1 ready_low = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check_val("midrst_req", {31'b0, mem_req}, 32'd0);
      check_val("midrst_pc_before", pc_out, 32'h108);
      @(posedge clk); #1;
      check_val("midrst_pc", pc_out, 32'h100);
      check_val("midrst_halted", {31'b0, halted}, 32'd0);
      check_reg(1, 32'd0);
      $display("reset mid-wait: pc=%h", pc_out);

      // Memory timeout: MAX_WAIT=4
      do_reset();
      run_until_halt(cyc);
      check_val("tmo_cause", {30'b0, halt_cause}, 32'd3);
      check_val("tmo_cycles", 32'(cyc), 32'd4);
      @(posedge clk); #1;
      check_val("tmo_req_drop", {31'b0, mem_req}, 32'd0);
      check_val("tmo_req_cycles", 32'(req_cycles), 32'd4);
      ready_low = 1'b0;
      $display("timeout: cause=%0d cycles=%0d", halt_cause, cyc);

      // Random programs against the reference interpreter
      for (int p = 0; p < 20; p++) begin
         gen_random_prog(24);
         wait_states = $urandom_range(0, 3);
         ref_run(wait_states);
         do_reset();
         run_until_halt(cyc);
         check_val("rnd_cause", {30'b0, halt_cause}, 32'(ref_cause));
         check_val("rnd_pc", pc_out, ref_pc);
         check_val("rnd_cycles", 32'(cyc), 32'(ref_cyc));
         check_val("rnd_stability", 32'(stab_err), 32'd0);
         for (int r = 0; r < 32; r++) check_reg(r, ref_regs[r]);
         for (int d = 0; d < 16; d++) check_val($sformatf("rnd_mem%0d", d), mem[DATA_W + d], ref_mem[DATA_W + d]);
         $display("random prog %0d: waits=%0d cycles=%0d cause=%0d pc=%h", p, wait_states, cyc, halt_cause, pc_out);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
